// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared mode encodings for the arbiter and ALU
package mem_arbiter_pkg;

    // Arbitration modes for mem_arbiter
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // ALU operation modes used by the processor core
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_mode_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester read arbiter for a single-port memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MODE         = ARB_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_strobe,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             lastGrant;
    logic [CNT_W-1:0] starveCnt;
    logic             pending;
    logic             pendingId;
    logic             grant0;
    logic             grant1;

    // Grant is combinational so a request can transfer in the cycle it appears
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                if (MODE == ARB_FIXED) begin
                    if (starveCnt == LIMIT) grant1 = 1'b1;
                    else                    grant0 = 1'b1;
                end else begin
                    if (lastGrant) grant0 = 1'b1;
                    else           grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        mem_strobe = grant0 | grant1;
        mem_addr   = '0;
        if (grant0)      mem_addr = req0_addr;
        else if (grant1) mem_addr = req1_addr;
    end

    // Responses pass mem_data straight through in the cycle after the strobe
    always_comb begin
        rsp0_valid = pending & ~pendingId & ~reset;
        rsp1_valid = pending &  pendingId & ~reset;
        rsp0_data  = rsp0_valid ? mem_data : '0;
        rsp1_data  = rsp1_valid ? mem_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGrant <= 1'b1;
            starveCnt <= '0;
            pending   <= 1'b0;
            pendingId <= 1'b0;
        end else begin
            pending <= grant0 | grant1;
            if (grant0 | grant1) begin
                pendingId <= grant1;
                lastGrant <= grant1;
            end
            if (MODE != ARB_FIXED || !req1_valid || grant1) begin
                starveCnt <= '0;
            end else if (starveCnt != LIMIT) begin
                starveCnt <= starveCnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL be the address width of the requester and memory ports.
REQ-002 Parameter DATA_W, default 8, SHALL be the read-data width.
REQ-003 Parameter MODE, default 0, SHALL select arbitration: 0 round-robin, 1 fixed priority (requester 0 high).
REQ-004 Parameter STARVE_LIMIT, default 4, SHALL be the number of consecutive lost cycles after which requester 1 is forced a grant in MODE 1.
REQ-005 Ports SHALL be: clk  in  1  sole clock, all registers on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req0_valid  in  1  requester 0 (processor fetch) wants a read.
REQ-008 req0_addr  in  ADDR_W  requester 0 read address.
REQ-009 req0_ready  out  1  requester 0 request accepted this cycle.
REQ-010 rsp0_valid  out  1  rsp0_data holds requester 0 read data.
REQ-011 rsp0_data  out  DATA_W  requester 0 read data.
REQ-012 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data SHALL mirror REQ-007..REQ-011 for requester 1 (debug/loader).
REQ-013 mem_addr  out  ADDR_W  address to the single-port memory.
REQ-014 mem_strobe  out  1  memory read enable.
REQ-015 mem_data  in  DATA_W  memory read data, valid one clk after the strobe.

Function
REQ-016 A request SHALL transfer in the cycle where reqN_valid and reqN_ready are both high.
REQ-017 At most one reqN_ready SHALL be high per cycle; reqN_ready SHALL never be high while reqN_valid is low.
REQ-018 In a transfer cycle, mem_strobe SHALL be 1 and mem_addr SHALL equal the granted reqN_addr; otherwise mem_strobe 0 and mem_addr 0.
REQ-019 Grant decision SHALL be combinational from valids and registered arbitration state (zero-cycle request latency).
REQ-020 rspN_valid SHALL be high exactly one cycle after requester N's transfer, with rspN_data = mem_data; otherwise rspN_valid 0 and rspN_data 0.
REQ-021 Back-to-back transfers SHALL be sustained every cycle (throughput 1 read/cycle, response latency 1).
REQ-022 MODE 0: with both valid, grant SHALL go to the requester not granted last; register last_grant resets to 1 (requester 0 wins first tie).
REQ-023 MODE 0: a single valid requester SHALL always be granted and SHALL update last_grant.
REQ-024 MODE 1: requester 0 SHALL win ties unless starve_cnt equals STARVE_LIMIT, in which case requester 1 wins.
REQ-025 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle req1_valid is high and not granted, and clear to 0 on any requester 1 grant or cycle with req1_valid low.
REQ-026 In MODE 0, starve_cnt SHALL stay 0.
REQ-027 A requester dropping valid before ready SHALL lose no state beyond REQ-025 clearing.

Reset
REQ-028 While reset is high, all outputs SHALL be 0, including reqN_ready and mem_strobe.
REQ-029 Reset SHALL clear last_grant to 1, starve_cnt to 0 and the pending-response registers immediately.
REQ-030 A read issued in the cycle before reset asserts SHALL produce no rspN_valid after reset releases.
REQ-031 First grant SHALL be possible in the first clk edge cycle after reset deasserts.

Structure
REQ-032 MODE encodings (ARB_RR=0, ARB_FIXED=1) SHALL live in a shared include alongside the ALU mode constants.
REQ-033 The block SHALL be one module with no sub-modules; response tracking SHALL be one registered granted-id bit plus one pending bit.

Verification
REQ-034 MODE 0, req0 addr 0x02 and req1 addr 0x10 valid together for 4 cycles -> grants 0,1,0,1; rsp0/rsp1 alternate, each one cycle later with memory[addr].
REQ-035 Only req0 valid, addrs 0x00..0x03 on consecutive cycles -> mem_strobe high 4 cycles, rsp0_valid high cycles 1..4 with data 0C,0A,1C,14.
REQ-036 MODE 1, STARVE_LIMIT 4, both valid continuously -> req1 granted on the 5th cycle, then pattern of four req0 grants, one req1.
REQ-037 Reset asserted one cycle after a req1 grant -> rsp1_valid never goes high; all outputs 0 during reset.
REQ-038 No valids for 10 cycles -> mem_strobe, readies, rsp valids stay 0; starve_cnt stays 0.
